// File: rtl/booth_secuenciador.sv
// Signed Booth radix-2 sequential multiplier: operand latch, FSM sequencer and
// add/subtract + arithmetic-shift datapath, with busy/done/valid status.
module booth_secuenciador #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic [WIDTH-1:0]     multiplicando,
  input  logic [WIDTH-1:0]     multiplicador,
  output logic [2*WIDTH-1:0]   producto,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [1:0]           estado
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUMA  = 2'd1,
    DESPL = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   acc, acc_d;
  logic [AW-1:0]   mcand, mcand_d;
  logic [WIDTH-1:0] q_reg, q_d;
  logic            q_1, q_1_d;
  logic [CW-1:0]   count, count_d;
  logic [PW-1:0]   producto_d;
  logic            busy_d, done_d, valid_d;
  logic            inicio_prev;
  logic            rise;

  assign rise   = inicio & ~inicio_prev;
  assign estado = state;

  // Next-state and datapath update for the Booth iteration
  always_comb begin
    state_d    = state;
    acc_d      = acc;
    mcand_d    = mcand;
    q_d        = q_reg;
    q_1_d      = q_1;
    count_d    = count;
    producto_d = producto;
    busy_d     = busy;
    done_d     = 1'b0;
    valid_d    = valid;

    case (state)
      IDLE: begin
        if (rise) begin
          mcand_d = {multiplicando[WIDTH-1], multiplicando};
          q_d     = multiplicador;
          acc_d   = '0;
          q_1_d   = 1'b0;
          count_d = CW'(WIDTH);
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SUMA;
        end
      end
      SUMA: begin
        case ({q_reg[0], q_1})
          2'b10:   acc_d = acc - mcand;
          2'b01:   acc_d = acc + mcand;
          default: acc_d = acc;
        endcase
        state_d = DESPL;
      end
      DESPL: begin
        acc_d   = {acc[AW-1], acc[AW-1:1]};
        q_d     = {acc[0], q_reg[WIDTH-1:1]};
        q_1_d   = q_reg[0];
        count_d = count - CW'(1);
        state_d = (count == CW'(1)) ? FIN : SUMA;
      end
      FIN: begin
        producto_d = {acc[WIDTH-1:0], q_reg};
        done_d     = 1'b1;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State, datapath and status registers with synchronous active-low reset
  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      q_reg       <= '0;
      q_1         <= 1'b0;
      count       <= '0;
      producto    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      valid       <= 1'b0;
      inicio_prev <= 1'b0;
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      mcand       <= mcand_d;
      q_reg       <= q_d;
      q_1         <= q_1_d;
      count       <= count_d;
      producto    <= producto_d;
      busy        <= busy_d;
      done        <= done_d;
      valid       <= valid_d;
      inicio_prev <= inicio;
    end
  end

endmodule

// File: tb/tb_booth_secuenciador.sv
// Self-checking bench for booth_secuenciador: directed and random products
// compared against plain signed multiplication, plus timing/status checks.
module tb_booth_secuenciador;

  logic        clk = 1'b0;
  logic        reset;
  logic        inicio;
  logic [7:0]  multiplicando;
  logic [7:0]  multiplicador;
  logic [15:0] producto;
  logic        busy;
  logic        done;
  logic        valid;
  logic [1:0]  estado;

  int errors = 0;
  int checks = 0;

  booth_secuenciador #(.WIDTH(8)) dut (
    .CLK100MHZ     (clk),
    .reset         (reset),
    .inicio        (inicio),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .producto      (producto),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .estado        (estado)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation; mode 0 plain, 1 hold inicio + change operands mid-run,
  // 2 extra rise while busy
  task automatic run_op(input logic [7:0] m, input logic [7:0] q, input int mode);
    int          mi;
    int          qi;
    logic [15:0] expv;
    logic [1:0]  est_q[$];
    logic [1:0]  e;
    mi   = int'($signed(m));
    qi   = int'($signed(q));
    expv = 16'(mi * qi);
    for (int k = 0; k < 8; k++) begin
      est_q.push_back(2'd1);
      est_q.push_back(2'd2);
    end
    est_q.push_back(2'd3);
    est_q.push_back(2'd0);

    multiplicando = m;
    multiplicador = q;
    inicio = 1'b1;
    step();
    e = est_q.pop_front();
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_valid_drop", 32'(valid), 32'd0);
    chk("accept_estado", 32'(estado), 32'(e));
    if (mode != 1) inicio = 1'b0;

    for (int i = 1; i <= 17; i++) begin
      if (mode == 1 && i == 5) begin
        multiplicando = 8'd2;
        multiplicador = 8'd2;
      end
      if (mode == 2 && i == 8) inicio = 1'b1;
      step();
      e = est_q.pop_front();
      chk("run_estado", 32'(estado), 32'(e));
      if (i < 17) begin
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_done", 32'(done), 32'd0);
      end else begin
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_valid", 32'(valid), 32'd1);
        chk("fin_producto", 32'(producto), 32'(expv));
      end
    end

    if (mode == 1) begin
      for (int k = 0; k < 82; k++) begin
        step();
        chk("hold_no_retrigger_done", 32'(done), 32'd0);
        chk("hold_no_retrigger_busy", 32'(busy), 32'd0);
      end
    end else if (mode == 2) begin
      for (int k = 0; k < 20; k++) begin
        step();
        chk("ignored_rise_busy", 32'(busy), 32'd0);
        chk("ignored_rise_estado", 32'(estado), 32'd0);
      end
    end
    inicio = 1'b0;
    step();
    chk("post_done_low", 32'(done), 32'd0);
    chk("post_valid_hold", 32'(valid), 32'd1);
    chk("post_producto_hold", 32'(producto), 32'(expv));
  endtask

  initial begin
    reset = 1'b0;
    inicio = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    repeat (3) step();
    chk("reset_producto", 32'(producto), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_estado", 32'(estado), 32'd0);
    reset = 1'b1;
    step();

    // Directed products including the extreme operands
    run_op(8'd3, 8'd5, 0);
    chk("p_3x5", 32'(producto), 32'h0000_000F);
    run_op(8'd6, 8'hF9, 0);
    chk("p_6xm7", 32'(producto), 32'h0000_FFD6);
    run_op(8'h80, 8'h80, 0);
    chk("p_m128xm128", 32'(producto), 32'h0000_4000);
    run_op(8'h80, 8'h7F, 0);
    chk("p_m128x127", 32'(producto), 32'h0000_C080);
    run_op(8'h00, 8'h80, 0);
    run_op(8'hFF, 8'hFF, 0);

    // Held start with operand changes mid-run, then a fresh rise
    run_op(8'd9, 8'hF3, 1);
    run_op(8'd7, 8'd11, 0);

    // Reset in the middle of an operation
    multiplicando = 8'd25;
    multiplicador = 8'd4;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    chk("midreset_producto", 32'(producto), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_valid", 32'(valid), 32'd0);
    chk("midreset_estado", 32'(estado), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("after_reset_no_done", 32'(done), 32'd0);
    end
    run_op(8'd25, 8'd4, 0);

    // Rise while busy is ignored
    run_op(8'hE5, 8'd13, 2);

    // Random operands
    for (int n = 0; n < 25; n++) begin
      run_op(8'($urandom), 8'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_secuenciador.md
Name: booth_secuenciador

Overview:
- Controller and datapath sequencer for the signed Booth radix-2 multiplication.
- Takes the debounced operands and the 500 ms-qualified start level from the input-reading stage.
- Latches both operands, then runs WIDTH add/subtract + arithmetic-shift iterations under an FSM.
- Presents a 2*WIDTH-bit signed product with busy/done/valid status for the display stage.

Parameters:
WIDTH, 8, operand width in bits (two's complement); product is 2*WIDTH bits.

Ports:
CLK100MHZ  input  1  system clock, 100 MHz; all logic on rising edge.
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
inicio  input  1  start request, level (held high while button qualified); operation starts on its rising edge only.
multiplicando  input  WIDTH  signed multiplicand M, sampled only when a start is accepted.
multiplicador  input  WIDTH  signed multiplier Q, sampled only when a start is accepted.
producto  output  2*WIDTH  signed product; updated only in DONE.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when producto is updated.
valid  output  1  level; producto holds a completed result.
estado  output  2  FSM state code for LED debug: IDLE=0, SUMA=1, DESPL=2, FIN=3.

Behaviour:
- Reset (reset==0 at an edge, any state): state IDLE, producto=0, busy=0, done=0, valid=0, inicio_prev=0, internal A/Q/Q_1/count=0. Takes priority over all other activity.
- Edge detect: inicio_prev <= inicio every cycle. Rise = inicio & ~inicio_prev.
- Internal registers:
  - A: WIDTH+1 bits, accumulator sign-extended by one bit so that M = -2^(WIDTH-1) never overflows.
  - M: WIDTH+1 bits, sign-extended.
  - Q: WIDTH bits.
  - Q_1: 1 bit.
  - count: clog2(WIDTH+1) bits.
- IDLE:
  - On rise: M<=sext(multiplicando), Q<=multiplicador, A<=0, Q_1<=0, count<=WIDTH, valid<=0, busy<=1, goto SUMA.
  - No rise: hold all registers.
- SUMA:
  - {Q[0],Q_1}=10: A<=A-M.
  - {Q[0],Q_1}=01: A<=A+M.
  - 00/11: A unchanged.
  - Goto DESPL.
- DESPL:
  - {A,Q,Q_1} <= arithmetic right shift by 1 (A MSB replicated); count<=count-1.
  - If count==1 goto FIN, else goto SUMA.
- FIN:
  - producto<={A[WIDTH-1:0],Q}, done<=1 (single cycle), valid<=1, busy<=0, goto IDLE.
  - done returns to 0 on the next edge.
- Latency: the edge that accepts the start is cycle 0; producto/done/valid appear after edge 2*WIDTH+1 (17 cycles for WIDTH=8). busy is high for exactly 2*WIDTH+1 cycles.
- Start handling:
  - inicio held high through completion does not retrigger; a new low→high transition is required.
  - A rise during busy is ignored and not queued; inicio_prev still tracks the input.
- Operands: multiplicando/multiplicador changes while busy have no effect on the running operation.
- Outputs after an operation: producto and valid hold after FIN until the next accepted start (valid then drops) or reset.
- Reset mid-operation: aborts immediately; no done pulse; outputs take reset values on that edge.
- Arithmetic: all add/subtract is WIDTH+1-bit two's complement, wrap-around discarded. The result is exact for the full signed range, including (-2^(WIDTH-1))*(-2^(WIDTH-1)).

Test Plan:
1. reset=0 for 3 cycles, then 1; inicio rises with M=3, Q=5 -> busy high 17 cycles; done pulses once at cycle 17; producto=16'h000F; valid=1.
2. M=6, Q=-7 (8'hF9) -> producto=16'hFFD6 (-42); estado sequence 1,2 repeated 8 times, then 3, then 0.
3. M=-128, Q=-128 -> producto=16'h4000. M=-128, Q=127 -> producto=16'hC080 (-16256).
4. inicio held high for 100 cycles after start -> exactly one done pulse. Operands changed to 2,2 at cycle 5 -> result still from latched operands. A second rise after release -> a new operation starts and valid drops on the accepting edge.
5. reset=0 at cycle 6 of an operation -> at that edge producto=0, busy=0, valid=0, estado=0; no done pulse. Next rise runs a normal 17-cycle operation.
6. inicio toggled low→high at cycle 8 while busy -> ignored; only one done pulse at cycle 17; no second operation follows.
